// File: rtl/nexys_starship_damage_sched.sv
// Central shield damage scheduler: counts down the break interval, picks a
// working shield from an LFSR-seeded scan, issues a one-tick break command
// with a repair combo, and ramps difficulty as breaks accumulate.
module nexys_starship_damage_sched #(
  parameter int         N_SUB            = 4,
  parameter logic [7:0] INIT_INTERVAL    = 8'd40,
  parameter logic [7:0] MIN_INTERVAL     = 8'd8,
  parameter logic [7:0] STEP             = 8'd4,
  parameter logic [2:0] BREAKS_PER_LEVEL = 3'd4,
  parameter logic [2:0] MAX_LEVEL        = 3'd7,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic       timer_clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken,
  output logic [3:0] break_req,
  output logic [3:0] break_combo,
  output logic [2:0] level,
  output logic [7:0] interval,
  output logic       all_broken
);

  typedef enum logic [1:0] {IDLE, COUNT, PICK, FIRE} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] brk_cnt_q, brk_cnt_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] level_q, level_d;
  logic [7:0] interval_q, interval_d;
  logic [3:0] break_req_q, break_req_d;
  logic [3:0] break_combo_q, break_combo_d;
  logic       all_broken_q, all_broken_d;

  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       found;
  logic [3:0] combo_raw;

  // Scan from the LFSR start candidate upward (mod 4); the lowest offset wins.
  always_comb begin
    cand     = lfsr_q[1:0];
    pick_idx = lfsr_q[1:0];
    found    = 1'b0;
    for (int k = N_SUB - 1; k >= 0; k--) begin
      cand = lfsr_q[1:0] + 2'(k);
      if (!broken[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

  assign combo_raw = lfsr_q[7:4];

  // Next-state and datapath updates; game-over overrides everything but the LFSR.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    brk_cnt_d     = brk_cnt_q;
    level_d       = level_q;
    interval_d    = interval_q;
    break_req_d   = 4'b0000;
    break_combo_d = break_combo_q;
    all_broken_d  = all_broken_q;
    lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      IDLE: begin
        brk_cnt_d     = 3'd0;
        level_d       = 3'd0;
        interval_d    = INIT_INTERVAL;
        break_combo_d = 4'h0;
        all_broken_d  = 1'b0;
        if (play_flag) begin
          cnt_d   = INIT_INTERVAL;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (play_flag) begin
          if (cnt_q == 8'd0) state_d = PICK;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      PICK: begin
        // Command and combo are registered on the way into FIRE so the shield
        // sees both together for the single FIRE tick.
        if (found) begin
          all_broken_d  = 1'b0;
          break_req_d   = 4'b0001 << pick_idx;
          break_combo_d = (combo_raw == 4'h0) ? 4'hF : combo_raw;
          state_d       = FIRE;
        end else begin
          all_broken_d = 1'b1;
        end
      end
      FIRE: begin
        // Difficulty freezes once the top level is reached, so the interval
        // settles at the level-7 value rather than creeping to the floor.
        if (brk_cnt_q == BREAKS_PER_LEVEL - 3'd1) begin
          brk_cnt_d = 3'd0;
          if (level_q != MAX_LEVEL) begin
            level_d = level_q + 3'd1;
            if ({1'b0, interval_q} >= ({1'b0, MIN_INTERVAL} + {1'b0, STEP}))
              interval_d = interval_q - STEP;
            else
              interval_d = MIN_INTERVAL;
          end
        end else begin
          brk_cnt_d = brk_cnt_q + 3'd1;
        end
        cnt_d   = interval_d;
        state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase

    if (gameover_ctrl) begin
      state_d       = IDLE;
      cnt_d         = 8'd0;
      brk_cnt_d     = 3'd0;
      level_d       = 3'd0;
      interval_d    = INIT_INTERVAL;
      break_req_d   = 4'b0000;
      break_combo_d = 4'h0;
      all_broken_d  = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      brk_cnt_q     <= 3'd0;
      lfsr_q        <= LFSR_SEED;
      level_q       <= 3'd0;
      interval_q    <= INIT_INTERVAL;
      break_req_q   <= 4'b0000;
      break_combo_q <= 4'h0;
      all_broken_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      brk_cnt_q     <= brk_cnt_d;
      lfsr_q        <= lfsr_d;
      level_q       <= level_d;
      interval_q    <= interval_d;
      break_req_q   <= break_req_d;
      break_combo_q <= break_combo_d;
      all_broken_q  <= all_broken_d;
    end
  end

  assign break_req   = break_req_q;
  assign break_combo = break_combo_q;
  assign level       = level_q;
  assign interval    = interval_q;
  assign all_broken  = all_broken_q;

endmodule

// File: tb/tb_nexys_starship_damage_sched.sv
// Self-checking bench for the shield damage scheduler.
module tb_nexys_starship_damage_sched;

  logic       timer_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic [3:0] broken = 4'b0000;
  logic [3:0] break_req;
  logic [3:0] break_combo;
  logic [2:0] level;
  logic [7:0] interval;
  logic       all_broken;

  int checks = 0;
  int fails = 0;

  logic [3:0] exp_q[$];

  int m_level = 0;
  int m_interval = 40;
  int m_brk = 0;

  nexys_starship_damage_sched dut (
    .timer_clk    (timer_clk),
    .Reset        (Reset),
    .play_flag    (play_flag),
    .gameover_ctrl(gameover_ctrl),
    .broken       (broken),
    .break_req    (break_req),
    .break_combo  (break_combo),
    .level        (level),
    .interval     (interval),
    .all_broken   (all_broken)
  );

  always #5 timer_clk = ~timer_clk;

  // Break command must never be multi-hot.
  always @(negedge timer_clk) begin
    if (!Reset) begin
      checks++;
      if (!$onehot0(break_req)) begin
        fails++;
        $display("[TB] FAIL onehot break_req=%b required zero- or one-hot", break_req);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Difficulty model: every fourth break raises the level until level 7.
  task automatic model_fire();
    m_brk++;
    if (m_brk == 4) begin
      m_brk = 0;
      if (m_level < 7) begin
        m_level++;
        m_interval = (m_interval - 4 < 8) ? 8 : m_interval - 4;
      end
    end
  endtask

  task automatic model_clear();
    m_level = 0;
    m_interval = 40;
    m_brk = 0;
  endtask

  // Counts rising edges until a break command is seen (bounded).
  task automatic wait_break(output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge timer_clk);
      n++;
      @(negedge timer_clk);
      if (break_req != 4'b0000) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge timer_clk);
    checks++; if (break_req !== 4'b0000) begin fails++; $display("[TB] FAIL reset_break_req got %b want 0000", break_req); end
    checks++; if (break_combo !== 4'h0) begin fails++; $display("[TB] FAIL reset_combo got %h want 0", break_combo); end
    checks++; if (level !== 3'd0) begin fails++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    checks++; if (interval !== 8'd40) begin fails++; $display("[TB] FAIL reset_interval got %0d want 40", interval); end
    checks++; if (all_broken !== 1'b0) begin fails++; $display("[TB] FAIL reset_all_broken got %b want 0", all_broken); end
    Reset = 1'b0;
    @(negedge timer_clk);
    model_clear();
  endtask

  task automatic test_first_break();
    int n; bit seen; logic [3:0] exp; logic [3:0] combo_seen;
    broken = 4'b1110;
    exp_q.push_back(4'b0001);
    play_flag = 1'b1;
    wait_break(n, seen);
    checks++; if (!seen || n - 1 != 42) begin fails++; $display("[TB] FAIL first_break_delay got %0d edges (seen=%0b) want 42", n - 1, seen); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    checks++; if (break_req !== exp) begin fails++; $display("[TB] FAIL first_break_target got %b want %b", break_req, exp); end
    checks++; if (break_combo == 4'h0) begin fails++; $display("[TB] FAIL first_break_combo got %h want nonzero", break_combo); end
    combo_seen = break_combo;
    @(negedge timer_clk);
    model_fire();
    checks++; if (break_req !== 4'b0000) begin fails++; $display("[TB] FAIL first_break_width got %b want 0000", break_req); end
    checks++; if (break_combo !== combo_seen) begin fails++; $display("[TB] FAIL combo_hold got %h want %h", break_combo, combo_seen); end
  endtask

  task automatic test_three_broken();
    logic [3:0] pats [3] = '{4'b0111, 4'b1011, 4'b1101};
    logic [3:0] reqs [3] = '{4'b1000, 4'b0100, 4'b0010};
    int n; bit seen; logic [3:0] exp;
    for (int i = 0; i < 3; i++) begin
      broken = pats[i];
      exp_q.push_back(reqs[i]);
      wait_break(n, seen);
      checks++; if (!seen || n + 1 != m_interval + 3) begin fails++; $display("[TB] FAIL scan_period[%0d] got %0d want %0d", i, n + 1, m_interval + 3); end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++; if (break_req !== exp) begin fails++; $display("[TB] FAIL scan_target[%0d] got %b want %b", i, break_req, exp); end
      @(negedge timer_clk);
      model_fire();
    end
    checks++; if (level !== 3'(m_level) || interval !== 8'(m_interval)) begin fails++; $display("[TB] FAIL level_up_1 got L%0d I%0d want L%0d I%0d", level, interval, m_level, m_interval); end
  endtask

  task automatic test_level_progression();
    int n; bit seen;
    broken = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      wait_break(n, seen);
      checks++; if (!seen || n + 1 != m_interval + 3) begin fails++; $display("[TB] FAIL prog_period[%0d] got %0d want %0d", i, n + 1, m_interval + 3); end
      @(negedge timer_clk);
      model_fire();
      checks++; if (level !== 3'(m_level) || interval !== 8'(m_interval)) begin fails++; $display("[TB] FAIL prog_level[%0d] got L%0d I%0d want L%0d I%0d", i, level, interval, m_level, m_interval); end
    end
    checks++; if (level !== 3'd7 || interval !== 8'd12) begin fails++; $display("[TB] FAIL saturation got L%0d I%0d want L7 I12", level, interval); end
  endtask

  task automatic test_all_broken();
    int n; bit seen; bit bad; logic [3:0] exp;
    broken = 4'b1111;
    seen = 1'b0; bad = 1'b0; n = 0;
    while (!seen && n < 100) begin
      @(posedge timer_clk); n++;
      @(negedge timer_clk);
      if (break_req != 4'b0000) bad = 1'b1;
      if (all_broken) seen = 1'b1;
    end
    checks++; if (!seen || bad) begin fails++; $display("[TB] FAIL all_broken_rise got seen=%0b stray=%0b want seen=1 stray=0", seen, bad); end
    bad = 1'b0;
    repeat (20) begin
      @(posedge timer_clk);
      @(negedge timer_clk);
      if (break_req != 4'b0000 || all_broken !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin fails++; $display("[TB] FAIL all_broken_hold got stray activity want none for 20 ticks"); end
    broken = 4'b1101;
    exp_q.push_back(4'b0010);
    wait_break(n, seen);
    checks++; if (!seen || n > 2) begin fails++; $display("[TB] FAIL all_broken_release got %0d edges (seen=%0b) want <=2", n, seen); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    checks++; if (break_req !== exp) begin fails++; $display("[TB] FAIL release_target got %b want %b", break_req, exp); end
    checks++; if (all_broken !== 1'b0) begin fails++; $display("[TB] FAIL release_all_broken got %b want 0", all_broken); end
    @(negedge timer_clk);
    model_fire();
  endtask

  task automatic test_pause();
    int n; bit seen; logic [3:0] exp;
    broken = 4'b1011;
    exp_q.push_back(4'b0100);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge timer_clk); n++;
      @(negedge timer_clk);
      if (n == 5) play_flag = 1'b0;
      if (n == 15) play_flag = 1'b1;
      if (break_req != 4'b0000) seen = 1'b1;
    end
    checks++; if (!seen || n != m_interval + 12) begin fails++; $display("[TB] FAIL pause_delay got %0d want %0d", n, m_interval + 12); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    checks++; if (break_req !== exp) begin fails++; $display("[TB] FAIL pause_target got %b want %b", break_req, exp); end
    @(negedge timer_clk);
    model_fire();
  endtask

  task automatic test_gameover();
    int n; bit seen; bit bad;
    gameover_ctrl = 1'b1;
    play_flag = 1'b0;
    @(negedge timer_clk);
    gameover_ctrl = 1'b0;
    model_clear();
    checks++; if (level !== 3'd0 || interval !== 8'd40 || break_combo !== 4'h0 || break_req !== 4'b0000) begin fails++; $display("[TB] FAIL gameover_idle got L%0d I%0d C%h R%b want L0 I40 C0 R0000", level, interval, break_combo, break_req); end
    bad = 1'b0;
    repeat (50) begin
      @(negedge timer_clk);
      if (break_req != 4'b0000) bad = 1'b1;
    end
    checks++; if (bad) begin fails++; $display("[TB] FAIL idle_quiet got break_req activity want none"); end
    broken = 4'b0000;
    play_flag = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_break(n, seen);
      checks++; if (!seen || n + ((i == 0) ? 0 : 1) != m_interval + 3) begin fails++; $display("[TB] FAIL regain_period[%0d] got %0d want %0d", i, n, m_interval + 3); end
      @(negedge timer_clk);
      model_fire();
    end
    checks++; if (level !== 3'(m_level) || m_level != 2) begin fails++; $display("[TB] FAIL level2 got %0d want 2", level); end
    repeat (5) @(negedge timer_clk);
    gameover_ctrl = 1'b1;
    @(negedge timer_clk);
    gameover_ctrl = 1'b0;
    model_clear();
    checks++; if (level !== 3'd0 || interval !== 8'd40 || break_combo !== 4'h0 || break_req !== 4'b0000) begin fails++; $display("[TB] FAIL gameover_count got L%0d I%0d C%h R%b want L0 I40 C0 R0000", level, interval, break_combo, break_req); end
  endtask

  task automatic test_reset_fire();
    int n; bit seen; logic [3:0] exp;
    broken = 4'b1110;
    exp_q.push_back(4'b0001);
    wait_break(n, seen);
    checks++; if (!seen || n - 1 != 42) begin fails++; $display("[TB] FAIL restart_delay got %0d want 42", n - 1); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    checks++; if (break_req !== exp) begin fails++; $display("[TB] FAIL restart_target got %b want %b", break_req, exp); end
    #1 Reset = 1'b1;
    #1;
    checks++; if (break_req !== 4'b0000 || level !== 3'd0 || break_combo !== 4'h0) begin fails++; $display("[TB] FAIL async_reset got R%b L%0d C%h want R0000 L0 C0", break_req, level, break_combo); end
    @(negedge timer_clk);
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    test_reset();
    test_first_break();
    test_three_broken();
    test_level_progression();
    test_all_broken();
    test_pause();
    test_gameover();
    test_reset_fire();
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
